// File: rtl/add_mul_mix_pkg.sv
// Shared types and widths for the add/multiply result accumulator.
package add_mul_mix_pkg;

  // Width of one upstream (a+b)*(c+d) product.
  localparam int RES_W = 8;

  // Width of the result counter (holds 0..16).
  localparam int CNT_W = 5;

  // Accumulator control states.
  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage : add_mul_mix_pkg

// File: rtl/add_mul_mix_acc.sv
// Accumulates ACC_LEN upstream products into one output word with a
// valid/ready handshake on both sides. A flush emits a partial batch early.
//
// Build option: define ADD_MUL_MIX_ACC_SAT_EN to clip the sum at
// 2^OUT_W-1 and report out_sat; otherwise the sum wraps and out_sat stays 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_ACC  | accepting products, cnt = 0..ACC_LEN-1, in_ready high
// ST_HOLD | output word presented, waiting for out_ready, inputs stalled
module add_mul_mix_acc
  import add_mul_mix_pkg::*;
#(
  parameter int ACC_LEN = 4,
  parameter int OUT_W   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] in_result,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_sat
);

  localparam logic [CNT_W-1:0] ACC_LEN_C = CNT_W'(ACC_LEN);
  localparam logic [OUT_W:0]   ACC_MAX   = {1'b0, {OUT_W{1'b1}}};

  state_e           state_q, state_d;
  logic [OUT_W:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [OUT_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_sat_q, out_sat_d;

  logic             xfer;
  logic [OUT_W:0]   add_sum;
  logic [OUT_W:0]   acc_upd;
  logic             sat_upd;
  logic [OUT_W:0]   acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sat_nxt;

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_HOLD);
  assign out_sum   = out_sum_q;
  assign out_cnt   = out_cnt_q;
  assign out_sat   = out_sat_q;

  assign xfer = in_valid & in_ready;

  // Add the zero-extended product; acc_q keeps its top bit clear so the
  // top bit of add_sum is the carry out of OUT_W.
  always_comb begin
    add_sum = acc_q + {{(OUT_W + 1 - RES_W){1'b0}}, in_result};
`ifdef ADD_MUL_MIX_ACC_SAT_EN
    sat_upd = sat_q | add_sum[OUT_W];
    acc_upd = sat_upd ? ACC_MAX : add_sum;
`else
    sat_upd = 1'b0;
    acc_upd = add_sum & ACC_MAX;
`endif
    acc_nxt = xfer ? acc_upd : acc_q;
    sat_nxt = xfer ? sat_upd : sat_q;
    cnt_nxt = xfer ? (cnt_q + CNT_W'(1)) : cnt_q;
  end

  // Next-state and register updates for both control states.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    out_sum_d = out_sum_q;
    out_cnt_d = out_cnt_q;
    out_sat_d = out_sat_q;
    case (state_q)
      ST_ACC: begin
        acc_d = acc_nxt;
        cnt_d = cnt_nxt;
        sat_d = sat_nxt;
        // A flush with nothing collected (and nothing arriving) is dropped.
        if ((xfer && (cnt_nxt == ACC_LEN_C)) ||
            (flush && (cnt_nxt != '0))) begin
          out_sum_d = acc_nxt[OUT_W-1:0];
          out_cnt_d = cnt_nxt;
          out_sat_d = sat_nxt;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ACC;
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      out_sum_q <= '0;
      out_cnt_q <= '0;
      out_sat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      out_sum_q <= out_sum_d;
      out_cnt_q <= out_cnt_d;
      out_sat_q <= out_sat_d;
    end
  end

endmodule : add_mul_mix_acc

// File: tb/tb_add_mul_mix_acc.sv
// Directed bench for add_mul_mix_acc: default instance checked through a
// scoreboard, plus an OUT_W=9 instance for wrap/saturation.
module tb_add_mul_mix_acc;
  import add_mul_mix_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       in_valid, in_ready, flush, out_valid, out_ready, out_sat;
  logic [7:0] in_result;
  logic [9:0] out_sum;
  logic [4:0] out_cnt;

  logic       v9, rdy9, fl9, ov9, or9, sat9;
  logic [7:0] r9;
  logic [8:0] sum9;
  logic [4:0] cnt9;

  typedef struct {
    logic [9:0] sum;
    logic [4:0] cnt;
    logic       sat;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  int   n0;

  always #5 clk = ~clk;

  add_mul_mix_acc dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_cnt(out_cnt),
    .out_sat(out_sat)
  );

  add_mul_mix_acc #(.ACC_LEN(4), .OUT_W(9)) dut9 (
    .clk(clk), .rst(rst), .in_valid(v9), .in_ready(rdy9),
    .in_result(r9), .flush(fl9), .out_valid(ov9),
    .out_ready(or9), .out_sum(sum9), .out_cnt(cnt9),
    .out_sat(sat9)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [9:0] s, input logic [4:0] c, input logic sat);
    exp_t x;
    x.sum = s;
    x.cnt = c;
    x.sat = sat;
    sb.push_back(x);
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic cyc(input logic v, input logic [7:0] r, input logic f, input logic ordy);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_result = r;
    flush     = f;
    out_ready = ordy;
  endtask

  task automatic send(input logic [7:0] r, input logic ordy);
    cyc(1'b1, r, 1'b0, ordy);
    chk("in_ready_acc", in_ready, 1);
  endtask

  // Scoreboard: every output handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        chk("unexpected_output", n_out, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_sum", out_sum, e.sum);
        chk("sb_cnt", out_cnt, e.cnt);
        chk("sb_sat", out_sat, e.sat);
      end
    end
  end

  initial begin
    in_valid = 0; in_result = 0; flush = 0; out_ready = 0;
    v9 = 0; r9 = 0; fl9 = 0; or9 = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_out_sat", out_sat, 0);

    // Four back-to-back 225s, output one cycle after the last accept.
    for (int i = 0; i < 4; i++) send(8'd225, 1'b1);
    push_exp(10'd900, 5'd4, 1'b0);
    cyc(0, 0, 0, 1);
    chk("lat_out_valid", out_valid, 1);
    chk("lat_in_ready", in_ready, 0);
    chk("lat_out_sum", out_sum, 900);
    cyc(0, 0, 0, 1);
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_out_valid", out_valid, 0);
    chk("one_output_900", n_out, 1);

    // Partial batch via flush, then next batch starts from zero.
    send(8'd10, 1'b1);
    send(8'd20, 1'b1);
    cyc(0, 0, 1, 1);
    push_exp(10'd30, 5'd2, 1'b0);
    cyc(0, 0, 0, 1);
    chk("flush_out_valid", out_valid, 1);
    chk("flush_out_cnt", out_cnt, 2);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) send(8'd1, 1'b1);
    push_exp(10'd4, 5'd4, 1'b0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    // Flush with an empty accumulator is dropped; with a same-cycle
    // transfer it emits a one-result word.
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    chk("flush_empty_ignored", out_valid, 0);
    cyc(1, 8'd7, 1, 1);
    chk("flush_xfer_in_ready", in_ready, 1);
    push_exp(10'd7, 5'd1, 1'b0);
    cyc(0, 0, 0, 1);
    chk("flush_xfer_valid", out_valid, 1);
    chk("flush_xfer_cnt", out_cnt, 1);
    cyc(0, 0, 0, 1);

    // Backpressure in HOLD: inputs stalled, output stable, flush ignored.
    n0 = n_out;
    send(8'd5, 1'b0);
    send(8'd6, 1'b0);
    send(8'd7, 1'b0);
    send(8'd8, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 8'd99, (i == 2), 0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_sum", out_sum, 26);
      chk("bp_out_cnt", out_cnt, 4);
    end
    push_exp(10'd26, 5'd4, 1'b0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_one_output", n_out, n0 + 1);
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
    push_exp(10'd10, 5'd4, 1'b0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    // Reset mid-batch discards the partial sum.
    n0 = n_out;
    send(8'd50, 1'b1);
    send(8'd60, 1'b1);
    send(8'd70, 1'b1);
    @(posedge clk);
    #3;
    rst = 1;
    in_valid = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_sum", out_sum, 0);
    chk("midrst_out_cnt", out_cnt, 0);
    @(posedge clk);
    #1;
    rst = 0;
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
    push_exp(10'd10, 5'd4, 1'b0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("midrst_one_output", n_out, n0 + 1);

    // Flush coincident with the completing transfer: a single word.
    send(8'd9, 1'b1);
    send(8'd9, 1'b1);
    send(8'd9, 1'b1);
    n0 = n_out;
    cyc(1, 8'd9, 1, 1);
    push_exp(10'd36, 5'd4, 1'b0);
    repeat (4) cyc(0, 0, 0, 1);
    chk("flush_last_one_output", n_out, n0 + 1);
    chk("flush_last_idle", out_valid, 0);

    // OUT_W=9 instance: 4 x 200 overflows 511.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      v9 = 1;
      r9 = 8'd200;
      chk("w9_in_ready", rdy9, 1);
    end
    @(posedge clk);
    #1;
    v9 = 0;
    chk("w9_out_valid", ov9, 1);
    chk("w9_out_cnt", cnt9, 4);
`ifdef ADD_MUL_MIX_ACC_SAT_EN
    chk("w9_out_sum", sum9, 511);
    chk("w9_out_sat", sat9, 1);
`else
    chk("w9_out_sum", sum9, 288);
    chk("w9_out_sat", sat9, 0);
`endif
    or9 = 1;
    @(posedge clk);
    #1;
    or9 = 0;
    chk("w9_released", ov9, 0);

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_add_mul_mix_acc

// File: doc/add_mul_mix_acc.md
ADD_MUL_MIX_ACC -- requirements
Module: add_mul_mix_acc

Interface
REQ-001 Parameter ACC_LEN, default 4: number of datapath results summed per output word; legal range 2..16.
REQ-002 Parameter OUT_W, default 10: width of the accumulated sum; legal range 8..16.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port in_valid, input, 1: in_result holds a valid 8-bit product from the upstream 4-bit add/multiply datapath.
REQ-006 Port in_ready, output, 1: block can accept in_result this cycle.
REQ-007 Port in_result, input, 8: unsigned (a+b)*(c+d) product, bit 7 = MSB.
REQ-008 Port flush, input, 1: single-cycle request to emit the partial sum now.
REQ-009 Port out_valid, output, 1: out_sum and out_cnt are valid.
REQ-010 Port out_ready, input, 1: downstream accepts the output word.
REQ-011 Port out_sum, output, OUT_W: accumulated unsigned sum.
REQ-012 Port out_cnt, output, 5: number of results contained in out_sum (1..ACC_LEN).
REQ-013 Port out_sat, output, 1: the sum was clipped (see Configuration).

Function
REQ-014 FSM states: ACC (accumulating, count 0..ACC_LEN-1) and HOLD (output presented).
REQ-015 In ACC: in_ready=1 and out_valid=0; in HOLD: in_ready=0 and out_valid=1.
REQ-016 An input transfer (in_valid & in_ready) adds zero-extended in_result to acc and increments cnt in the same edge.
REQ-017 When a transfer makes cnt equal ACC_LEN: out_sum and out_cnt are registered from the updated values and the FSM enters HOLD on that edge; latency is 1 cycle from the last input to out_valid.
REQ-018 Flush in ACC with cnt>0: the current sum (including a same-cycle transfer) is emitted and the FSM enters HOLD.
REQ-019 Flush in ACC with cnt=0 and no same-cycle transfer: ignored; flush in HOLD: ignored.
REQ-020 In HOLD, out_sum, out_cnt and out_sat are stable until out_valid & out_ready.
REQ-021 An output handshake clears acc, cnt and the sat flag and returns the FSM to ACC on that edge; in_ready rises the following cycle, with no same-cycle bypass.
REQ-022 Summation is unsigned with no negative values; acc is OUT_W+1 bits internally to detect carry out.

Reset
REQ-023 Asserting rst at any time, including mid-accumulation or during HOLD, sets the FSM to ACC and clears acc, cnt, out_sum, out_cnt and out_sat.
REQ-024 Immediately after reset, out_valid=0 and in_ready=1; any partial sum is discarded and no output is emitted.

Configuration
REQ-025 Macro ADD_MUL_MIX_ACC_SAT_EN defined: on carry out of OUT_W, acc holds 2^OUT_W-1 for the rest of the batch and out_sat=1 with the emitted word.
REQ-026 Macro ADD_MUL_MIX_ACC_SAT_EN undefined: the sum wraps modulo 2^OUT_W and out_sat is tied to 0.

Structure
REQ-027 A shared package add_mul_mix_pkg holds the FSM state enum, the 8-bit result width constant RES_W, and the count width constant CNT_W=5.
REQ-028 The block is a single module with no sub-module; the adder-and-saturate logic is inline.

Verification
REQ-029 Default params, results 225,225,225,225 with back-to-back valid -> one output with out_sum=900, out_cnt=4, out_sat=0, 1 cycle after the 4th accept.
REQ-030 Results 10,20 then flush -> out_sum=30, out_cnt=2; the following batch starts from 0.
REQ-031 OUT_W=9, results 200 x4 -> with SAT_EN: out_sum=511, out_sat=1; without SAT_EN: out_sum=288, out_sat=0.
REQ-032 out_ready held low 5 cycles in HOLD while in_valid=1 -> in_ready=0, out_sum stable, no input lost or accepted.
REQ-033 rst pulsed after 3 accepted results -> no output is produced; the next 4 results 1,2,3,4 give out_sum=10.
REQ-034 Flush in the same cycle as the 4th transfer -> exactly one output with out_cnt=4 and no duplicate output.
